// File: rtl/delay_pipe.sv
// delay_pipe -- fixed-depth valid/data delay line with a selectable output tap.
//
// Purpose:
//   Holds DEPTH stages, each a valid bit plus a WIDTH-bit payload register.
//   Every non-stalled, non-flushed cycle the line shifts by one stage: a new
//   beat (or bubble) enters stage 0 and whatever sits in the last stage is
//   dropped. The output is a combinational pick of one stage (the tap), so a
//   beat presented in cycle t is visible in cycle t+T when the effective tap
//   is T.
//
// Handshake:
//   io_in_ready is high exactly when the line will shift on the coming edge
//   (no stall, no flush). A beat is taken when io_in_valid && io_in_ready;
//   with io_in_ready low the beat is ignored and the source must hold it.
//   The output side has no backpressure: io_out_valid/io_out_bits show the
//   tapped stage every cycle, and io_stall is the only way to freeze it.
//
// Ports:
//   clock         in   sole clock, rising edge
//   reset         in   synchronous active-high reset
//   io_in_valid   in   input beat present
//   io_in_bits    in   [WIDTH] input payload
//   io_in_ready   out  input accepted this cycle (!io_stall && !io_flush)
//   io_stall      in   freeze every stage
//   io_flush      in   invalidate every in-flight beat (wins over stall)
//   io_tap        in   [TAPW] output stage select 1..DEPTH; 0 or >DEPTH -> DEPTH
//   io_out_valid  out  valid bit of the tapped stage
//   io_out_bits   out  [WIDTH] payload of the tapped stage, zero when invalid
//   io_count      out  [TAPW] registered number of valid stages
//   io_empty      out  io_count == 0

module delay_pipe #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 5,
  parameter int TAPW  = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  input  logic [WIDTH-1:0] io_in_bits,
  output logic             io_in_ready,
  input  logic             io_stall,
  input  logic             io_flush,
  input  logic [TAPW-1:0]  io_tap,
  output logic             io_out_valid,
  output logic [WIDTH-1:0] io_out_bits,
  output logic [TAPW-1:0]  io_count,
  output logic             io_empty
);

  // Index width for picking one of DEPTH stages; a single stage still needs
  // a one-bit index so the select expression stays well formed.
  localparam int SELW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] r_v;
  logic [WIDTH-1:0] r_d [DEPTH];
  logic [TAPW-1:0]  r_count;

  logic             w_shift;
  logic [SELW-1:0]  w_sel;

  assign w_shift     = !io_stall && !io_flush;
  assign io_in_ready = w_shift;

  // Stage storage. Flush only clears the valid bits; stale payloads are
  // harmless because the output mask hides data of invalid stages.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_v     <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_d[i] <= '0;
      end
    end else if (io_flush) begin
      r_v     <= '0;
      r_count <= '0;
    end else if (!io_stall) begin
      r_v[0] <= io_in_valid;
      r_d[0] <= io_in_bits;
      for (int i = 1; i < DEPTH; i++) begin
        r_v[i] <= r_v[i-1];
        r_d[i] <= r_d[i-1];
      end
      // One beat may enter and one may fall off the end; the true result
      // never exceeds DEPTH, so modular arithmetic in TAPW bits is exact.
      r_count <= r_count + TAPW'(io_in_valid) - TAPW'(r_v[DEPTH-1]);
    end
  end

  // Out-of-range taps (0 or beyond the last stage) read the last stage.
  always_comb begin
    w_sel = SELW'(DEPTH - 1);
    if (io_tap != '0 && int'(io_tap) <= DEPTH) begin
      w_sel = SELW'(io_tap - TAPW'(1));
    end
  end

  assign io_out_valid = r_v[w_sel];
  assign io_out_bits  = r_v[w_sel] ? r_d[w_sel] : '0;
  assign io_count     = r_count;
  assign io_empty     = (r_count == '0);

endmodule

// File: tb/tb_delay_pipe.sv
// tb_delay_pipe -- self-checking bench for delay_pipe.
//
// Two instances: the default 36-bit, 5-stage line and a 1-stage, 8-bit line
// sharing the same control inputs. A queue-based reference model tracks
// both. Directed vectors carry hand-derived expectations; hand-written
// sequences cover tap switching, bubbles and reset over stall; a random run
// finishes the job.

module tb_delay_pipe;

  localparam int WIDTH = 36;
  localparam int DEPTH = 5;
  localparam int TAPW  = 3;

  // ---------------- clock / reset / stimulus signals ----------------
  logic             clock;
  logic             rst;
  logic             stall;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_bits;
  logic [TAPW-1:0]  tap;

  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_bits;
  logic [TAPW-1:0]  count;
  logic             empty;

  logic             d1_ready;
  logic             d1_out_valid;
  logic [7:0]       d1_out_bits;
  logic [0:0]       d1_count;
  logic             d1_empty;

  int n_checks;
  int n_err;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  delay_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAPW(TAPW)) u_dut (
    .clock        (clock),
    .reset        (rst),
    .io_in_valid  (in_valid),
    .io_in_bits   (in_bits),
    .io_in_ready  (in_ready),
    .io_stall     (stall),
    .io_flush     (flush),
    .io_tap       (tap),
    .io_out_valid (out_valid),
    .io_out_bits  (out_bits),
    .io_count     (count),
    .io_empty     (empty)
  );

  delay_pipe #(.WIDTH(8), .DEPTH(1)) u_dut1 (
    .clock        (clock),
    .reset        (rst),
    .io_in_valid  (in_valid),
    .io_in_bits   (in_bits[7:0]),
    .io_in_ready  (d1_ready),
    .io_stall     (stall),
    .io_flush     (flush),
    .io_tap       (tap[0:0]),
    .io_out_valid (d1_out_valid),
    .io_out_bits  (d1_out_bits),
    .io_count     (d1_count),
    .io_empty     (d1_empty)
  );

  // ---------------- reference model ----------------
  // Stage contents as an ordered list, newest at the front.
  logic             m_v[$];
  logic [WIDTH-1:0] m_d[$];
  logic             m1_v;
  logic [7:0]       m1_d;

  task automatic model_reset();
    m_v.delete();
    m_d.delete();
    for (int i = 0; i < DEPTH; i++) begin
      m_v.push_back(1'b0);
      m_d.push_back('0);
    end
    m1_v = 1'b0;
    m1_d = '0;
  endtask

  task automatic model_update();
    if (rst) begin
      model_reset();
    end else if (flush) begin
      foreach (m_v[i]) m_v[i] = 1'b0;
      m1_v = 1'b0;
    end else if (!stall) begin
      m_v.push_front(in_valid);
      m_d.push_front(in_bits);
      void'(m_v.pop_back());
      void'(m_d.pop_back());
      m1_v = in_valid;
      m1_d = in_bits[7:0];
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int eff;
    int cnt;
    logic ev;
    logic [WIDTH-1:0] eb;
    eff = (int'(tap) == 0 || int'(tap) > DEPTH) ? DEPTH : int'(tap);
    ev  = m_v[eff-1];
    eb  = ev ? m_d[eff-1] : '0;
    cnt = 0;
    foreach (m_v[i]) cnt += int'(m_v[i]);
    chk("model_ready",     64'(in_ready),  64'(!stall && !flush));
    chk("model_out_valid", 64'(out_valid), 64'(ev));
    chk("model_out_bits",  64'(out_bits),  64'(eb));
    chk("model_count",     64'(count),     64'(cnt));
    chk("model_empty",     64'(empty),     64'(cnt == 0));
    chk("d1_ready",        64'(d1_ready),     64'(!stall && !flush));
    chk("d1_out_valid",    64'(d1_out_valid), 64'(m1_v));
    chk("d1_out_bits",     64'(d1_out_bits),  64'(m1_v ? m1_d : 8'h00));
    chk("d1_count",        64'(d1_count),     64'(m1_v));
    chk("d1_empty",        64'(d1_empty),     64'(!m1_v));
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input bit r, input bit st, input bit fl, input bit iv,
                        input logic [WIDTH-1:0] ib, input logic [TAPW-1:0] tp);
    rst      = r;
    stall    = st;
    flush    = fl;
    in_valid = iv;
    in_bits  = ib;
    tap      = tp;
  endtask

  // Apply inputs, let combinational outputs settle, compare with the model.
  task automatic drive(input bit r, input bit st, input bit fl, input bit iv,
                       input logic [WIDTH-1:0] ib, input logic [TAPW-1:0] tp);
    set_in(r, st, fl, iv, ib, tp);
    #1;
    check_model();
  endtask

  // Advance one clock; the model consumes the same inputs the DUT sampled.
  task automatic tick();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic idle(input int n, input logic [TAPW-1:0] tp);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, '0, tp);
      tick();
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit               st;
    bit               fl;
    bit               iv;
    logic [WIDTH-1:0] ib;
    logic [TAPW-1:0]  tp;
    bit               e_rdy;
    bit               e_ov;
    logic [WIDTH-1:0] e_ob;
    int               e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit st, input bit fl, input bit iv, input logic [WIDTH-1:0] ib,
                     input logic [TAPW-1:0] tp, input bit e_rdy, input bit e_ov,
                     input logic [WIDTH-1:0] e_ob, input int e_cnt);
    vec_t v;
    v = '{st, fl, iv, ib, tp, e_rdy, e_ov, e_ob, e_cnt};
    vecs.push_back(v);
  endtask

  // ---------------- main test ----------------
  initial begin
    logic [63:0] rnd;
    n_checks = 0;
    n_err    = 0;
    model_reset();

    // Reset for two edges, checking outputs while reset is still held.
    set_in(1, 0, 0, 1, 36'h77, 5);
    tick();
    drive(1, 0, 0, 1, 36'h77, 5);
    chk("rst_hold_out_valid", 64'(out_valid), 64'd0);
    chk("rst_hold_empty",     64'(empty),     64'd1);
    tick();
    drive(0, 0, 0, 0, '0, 5);
    chk("reset_count",     64'(count),     64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_bits",  64'(out_bits),  64'd0);
    chk("reset_ready",     64'(in_ready),  64'd1);
    tick();

    // Stream 1,2,3 at tap 5: visible in cycles 5,6,7, count peaks at 3.
    add(0,0,1,36'h1,5, 1,0,36'h0,0);
    add(0,0,1,36'h2,5, 1,0,36'h0,1);
    add(0,0,1,36'h3,5, 1,0,36'h0,2);
    add(0,0,0,36'h0,5, 1,0,36'h0,3);
    add(0,0,0,36'h0,5, 1,0,36'h0,3);
    add(0,0,0,36'h0,5, 1,1,36'h1,3);
    add(0,0,0,36'h0,5, 1,1,36'h2,2);
    add(0,0,0,36'h0,5, 1,1,36'h3,1);
    add(0,0,0,36'h0,5, 1,0,36'h0,0);
    // One beat, two stall cycles (with an ignored input): appears at cycle 7.
    add(0,0,1,36'hA,5,   1,0,36'h0,0);
    add(0,0,0,36'h0,5,   1,0,36'h0,1);
    add(1,0,1,36'hBAD,5, 0,0,36'h0,1);
    add(1,0,1,36'hBAD,5, 0,0,36'h0,1);
    add(0,0,0,36'h0,5,   1,0,36'h0,1);
    add(0,0,0,36'h0,5,   1,0,36'h0,1);
    add(0,0,0,36'h0,5,   1,0,36'h0,1);
    add(0,0,0,36'h0,5,   1,1,36'hA,1);
    add(0,0,0,36'h0,5,   1,0,36'h0,0);
    // Fill five beats, flush with a valid input that must never show up.
    add(0,0,1,36'h21,5, 1,0,36'h0,0);
    add(0,0,1,36'h22,5, 1,0,36'h0,1);
    add(0,0,1,36'h23,5, 1,0,36'h0,2);
    add(0,0,1,36'h24,5, 1,0,36'h0,3);
    add(0,0,1,36'h25,5, 1,0,36'h0,4);
    add(0,1,1,36'h99,5, 0,1,36'h21,5);
    add(0,0,0,36'h0,1,  1,0,36'h0,0);
    add(0,0,0,36'h0,5,  1,0,36'h0,0);
    add(0,0,0,36'h0,3,  1,0,36'h0,0);
    add(0,0,0,36'h0,2,  1,0,36'h0,0);
    // Stall and flush together behave as a flush on an empty line.
    add(1,1,1,36'h5,5,  0,0,36'h0,0);
    add(0,0,0,36'h0,1,  1,0,36'h0,0);

    foreach (vecs[k]) begin
      set_in(0, vecs[k].st, vecs[k].fl, vecs[k].iv, vecs[k].ib, vecs[k].tp);
      #1;
      chk($sformatf("vec%0d_ready", k),     64'(in_ready),  64'(vecs[k].e_rdy));
      chk($sformatf("vec%0d_out_valid", k), 64'(out_valid), 64'(vecs[k].e_ov));
      chk($sformatf("vec%0d_out_bits", k),  64'(out_bits),  64'(vecs[k].e_ob));
      chk($sformatf("vec%0d_count", k),     64'(count),     64'(vecs[k].e_cnt));
      chk($sformatf("vec%0d_empty", k),     64'(empty),     64'(vecs[k].e_cnt == 0));
      check_model();
      tick();
    end

    // Tap 2 stream, then tap 0 clamps to the last stage mid-stream.
    for (int k = 0; k < 7; k++) begin
      drive(0, 0, 0, k < 5, 36'(16 + k), (k < 5) ? 3'd2 : 3'd0);
      if (k >= 2 && k < 5) begin
        chk("tap2_valid", 64'(out_valid), 64'd1);
        chk("tap2_bits",  64'(out_bits),  64'(16 + k - 2));
      end
      if (k >= 5) begin
        chk("clamp_valid", 64'(out_valid), 64'd1);
        chk("clamp_bits",  64'(out_bits),  64'(16 + k - 5));
      end
      tick();
    end
    idle(6, 5);

    // Bubble between two beats survives, with the payload masked to zero.
    drive(0, 0, 0, 1, 36'h55, 3);  tick();
    drive(0, 0, 0, 0, 36'hFFF, 3); tick();
    drive(0, 0, 0, 1, 36'hAA, 3);  tick();
    drive(0, 0, 0, 0, '0, 3);
    chk("bubble_first_valid",  64'(out_valid), 64'd1);
    chk("bubble_first_bits",   64'(out_bits),  64'h55);
    tick();
    drive(0, 0, 0, 0, '0, 3);
    chk("bubble_gap_valid",    64'(out_valid), 64'd0);
    chk("bubble_gap_bits",     64'(out_bits),  64'd0);
    tick();
    drive(0, 0, 0, 0, '0, 3);
    chk("bubble_second_valid", 64'(out_valid), 64'd1);
    chk("bubble_second_bits",  64'(out_bits),  64'hAA);
    tick();
    idle(6, 5);

    // Reset with three beats in flight and stall high: reset wins.
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 1, 36'(8'h31 + k), 5);
      tick();
    end
    drive(1, 1, 0, 1, 36'h77, 5);
    tick();
    drive(0, 0, 0, 1, 36'h3C, 1);
    chk("rst_stall_count",     64'(count),     64'd0);
    chk("rst_stall_out_valid", 64'(out_valid), 64'd0);
    chk("rst_stall_out_bits",  64'(out_bits),  64'd0);
    chk("rst_stall_empty",     64'(empty),     64'd1);
    tick();
    // The first beat after reset follows the normal tap latency.
    for (int k = 1; k < 5; k++) begin
      drive(0, 0, 0, 0, '0, 5);
      tick();
    end
    drive(0, 0, 0, 0, '0, 5);
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_bits",  64'(out_bits),  64'h3C);
    tick();

    // Random traffic against the model.
    for (int k = 0; k < 800; k++) begin
      rnd = {$urandom(), $urandom()};
      drive($urandom_range(0, 63) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 1) == 1,
            rnd[WIDTH-1:0],
            3'($urandom_range(0, 7)));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/delay_pipe.md
DELAY_PIPE -- requirements
Module: delay_pipe

Interface
REQ-001 Parameter WIDTH, default 36, payload width in bits (>=1).
REQ-002 Parameter DEPTH, default 5, number of pipeline stages (>=1).
REQ-003 Parameter TAPW, default $clog2(DEPTH+1), width of io_tap.
REQ-004 clock  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 io_in_valid  in  1  input beat present.
REQ-007 io_in_bits  in  WIDTH  input payload.
REQ-008 io_in_ready  out  1  input accepted this cycle; combinational = !io_stall && !io_flush.
REQ-009 io_stall  in  1  freeze all stages.
REQ-010 io_flush  in  1  invalidate all in-flight beats.
REQ-011 io_tap  in  TAPW  output stage select, 1..DEPTH.
REQ-012 io_out_valid  out  1  valid bit of selected stage.
REQ-013 io_out_bits  out  WIDTH  payload of selected stage, masked.
REQ-014 io_count  out  TAPW  number of valid beats across all DEPTH stages (registered).
REQ-015 io_empty  out  1  high when io_count == 0.

Function
REQ-016 Block SHALL hold DEPTH stages, each a valid bit v[i] plus WIDTH data register d[i], i = 0..DEPTH-1.
REQ-017 Shift cycle (stall=0, flush=0): v[0] <= io_in_valid, d[0] <= io_in_bits, v[i] <= v[i-1], d[i] <= d[i-1] for i>=1.
REQ-018 Stall cycle (stall=1, flush=0): all v[] and d[] SHALL hold; io_in_valid ignored (beat not accepted, io_in_ready=0).
REQ-019 Flush cycle (flush=1, any stall): all v[] SHALL clear next edge; d[] may hold; input beat dropped.
REQ-020 Priority: reset > flush > stall > shift.
REQ-021 Effective tap T = io_tap when 1 <= io_tap <= DEPTH; io_tap == 0 or > DEPTH SHALL be treated as DEPTH.
REQ-022 io_out_valid = v[T-1]; io_out_bits = d[T-1] when v[T-1]=1, else all zeros (combinational select of registered state).
REQ-023 Latency: with no stall/flush, beat presented in cycle t SHALL appear at output in cycle t+T; each stall cycle adds exactly one cycle.
REQ-024 io_tap may change any cycle; output SHALL reflect the new tap the same cycle; no beat reordering in stage storage.
REQ-025 io_count next value: shift -> count + io_in_valid - v[DEPTH-1]; stall -> count; flush/reset -> 0; SHALL always equal popcount(v[]).
REQ-026 Beats leaving v[DEPTH-1] on a shift SHALL be discarded regardless of tap.
REQ-027 Bubbles (io_in_valid=0) SHALL propagate as invalid stages with no collapse.
REQ-028 Simultaneous stall and flush SHALL behave as flush.
REQ-029 DEPTH=1 SHALL be supported: single stage, T always 1.

Reset
REQ-030 On reset high at a rising edge: all v[] = 0, all d[] = 0, io_count = 0.
REQ-031 During and after reset: io_out_valid=0, io_out_bits=0, io_empty=1; io_in_ready follows REQ-008.
REQ-032 Reset asserted mid-stream SHALL discard all in-flight beats; first beat after reset deassert follows REQ-023.

Verification
REQ-033 Reset then stream 0x1,0x2,0x3 valid on consecutive cycles, tap=5 -> outputs 0x1,0x2,0x3 valid in cycles 5,6,7 after first input; io_count peaks at 3.
REQ-034 Send 0xA at cycle 0, stall cycles 2-3, tap=5 -> 0xA valid at cycle 7; io_in_ready=0 in cycles 2-3; io_count stays 1 throughout until drained.
REQ-035 Fill 5 valid beats, assert flush one cycle with io_in_valid=1 -> next cycle io_count=0, io_empty=1, no output valid; flushed-cycle input never appears.
REQ-036 Stream 0x10..0x14 with tap=2 -> each beat valid 2 cycles after input; switching to tap=0 mid-stream -> output immediately taken from stage 5 (clamp).
REQ-037 Alternate valid/invalid inputs 0x55,bubble,0xAA -> output valid,invalid,valid pattern preserved; io_out_bits=0 on bubble cycle.
REQ-038 Assert reset with 3 beats in flight plus stall=1 -> next cycle io_count=0, io_out_valid=0; reset overrides stall.
